// File: rtl/fgyrus_lb_mux.sv
`default_nettype none
// ============================================================================
// Module      : fgyrus_lb_mux
// Description : Local-bus decoder for the FGYRUS block. Routes NIOS local-bus
//               accesses to the control/status registers (block code 0) or to
//               one of P_NUM_RAMS attached RAMs (block code k+1). Reads go
//               through a small FSM with a fixed P_RD_DELAY latency; writes
//               are registered one cycle. Holds masked W1C interrupt status.
//               Optional macro FGYRUS_LB_ERR_CNT_EN adds a saturating
//               protocol-error counter at register offset 0x06.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fgyrus_lb_mux #(
    parameter int P_LB_ADDR_W  = 12,
    parameter int P_LB_DATA_W  = 32,
    parameter int P_RAM_ADDR_W = 8,
    parameter int P_NUM_RAMS   = 4,
    parameter int P_RD_DELAY   = 4
) (
    input  logic                              clk_ir,
    input  logic                              rst_il,
    input  logic                              lb_rd_en_ih,
    input  logic                              lb_wr_en_ih,
    input  logic [P_LB_ADDR_W-1:0]            lb_addr_id,
    input  logic [P_LB_DATA_W-1:0]            lb_wr_data_id,
    output logic                              lb_rd_valid_od,
    output logic                              lb_wr_valid_od,
    output logic [P_LB_DATA_W-1:0]            lb_rd_data_od,
    output logic [P_RAM_ADDR_W-1:0]           ram_addr_od,
    output logic [P_LB_DATA_W-1:0]            ram_wr_data_od,
    output logic [P_NUM_RAMS-1:0]             ram_wr_en_oh,
    output logic [P_NUM_RAMS-1:0]             ram_rd_en_oh,
    input  logic [P_NUM_RAMS*P_LB_DATA_W-1:0] ram_rd_data_id,
    output logic                              fgyrus_en_oh,
    output logic [3:0]                        fgyrus_post_norm_od,
    input  logic                              fgyrus_busy_ih,
    input  logic [2:0]                        fgyrus_fsm_pstate_id,
    input  logic                              fgyrus_fft_done_ih,
    input  logic                              irq_rst_ih,
    output logic                              irq_oh
);

    localparam int CODE_W = 4;
    // Wait counter only needs to hold P_RD_DELAY-3
    localparam int CNT_W  = (P_RD_DELAY > 4) ? $clog2(P_RD_DELAY - 2) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(P_RD_DELAY - 3);

    localparam logic [CODE_W-1:0] CODE_REGS = '0;

    localparam logic [P_RAM_ADDR_W-1:0] REG_CONTROL  = P_RAM_ADDR_W'(0);
    localparam logic [P_RAM_ADDR_W-1:0] REG_STATUS   = P_RAM_ADDR_W'(1);
    localparam logic [P_RAM_ADDR_W-1:0] REG_PSTATE   = P_RAM_ADDR_W'(2);
    localparam logic [P_RAM_ADDR_W-1:0] REG_POSTNORM = P_RAM_ADDR_W'(3);
    localparam logic [P_RAM_ADDR_W-1:0] REG_IRQ_STAT = P_RAM_ADDR_W'(4);
    localparam logic [P_RAM_ADDR_W-1:0] REG_IRQ_MASK = P_RAM_ADDR_W'(5);
`ifdef FGYRUS_LB_ERR_CNT_EN
    localparam logic [P_RAM_ADDR_W-1:0] REG_ERR_CNT  = P_RAM_ADDR_W'(6);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } rd_state_t;

    rd_state_t                 rd_state;
    logic [CODE_W-1:0]         rd_code;
    logic [P_RAM_ADDR_W-1:0]   rd_off;
    logic [CNT_W-1:0]          wait_cnt;

    logic                      irq_mask;
    logic                      irq_status;
    logic                      irq_status_nxt;
    logic                      irq_mask_nxt;

    logic [CODE_W-1:0]         acc_code;
    logic [P_RAM_ADDR_W-1:0]   acc_off;
    logic                      acc_is_reg;
    logic [P_NUM_RAMS-1:0]     acc_onehot;
    logic                      rd_accept;

    logic                      wr_reg;
    logic                      wr_control;
    logic                      wr_postnorm;
    logic                      wr_irq_stat;
    logic                      wr_irq_mask;

    logic [P_LB_DATA_W-1:0]    reg_rd_data;
    logic [P_LB_DATA_W-1:0]    cap_data;

    assign acc_code   = lb_addr_id[P_LB_ADDR_W-1 -: CODE_W];
    assign acc_off    = lb_addr_id[P_RAM_ADDR_W-1:0];
    assign acc_is_reg = (acc_code == CODE_REGS);

    // A read is only taken when the FSM is free and no write competes for the bus
    assign rd_accept  = lb_rd_en_ih && !lb_wr_en_ih && (rd_state == S_IDLE);

    assign wr_reg      = lb_wr_en_ih && acc_is_reg;
    assign wr_control  = wr_reg && (acc_off == REG_CONTROL);
    assign wr_postnorm = wr_reg && (acc_off == REG_POSTNORM);
    assign wr_irq_stat = wr_reg && (acc_off == REG_IRQ_STAT);
    assign wr_irq_mask = wr_reg && (acc_off == REG_IRQ_MASK);

    // One-hot RAM select; codes 0 and above P_NUM_RAMS select no RAM
    always_comb begin
        acc_onehot = '0;
        for (int k = 0; k < P_NUM_RAMS; k++) begin
            acc_onehot[k] = (acc_code == CODE_W'(k + 1));
        end
    end

    // Done pulse has priority over both clear sources so no event is lost
    assign irq_status_nxt = fgyrus_fft_done_ih ||
                            (irq_status && !(irq_rst_ih || (wr_irq_stat && lb_wr_data_id[0])));
    assign irq_mask_nxt   = wr_irq_mask ? lb_wr_data_id[0] : irq_mask;

`ifdef FGYRUS_LB_ERR_CNT_EN
    logic [15:0] err_cnt;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    logic        acc_is_bad;
    logic        rd_drop;
    logic        wr_err_cnt;

    assign acc_is_bad = (acc_code > CODE_W'(P_NUM_RAMS));
    assign rd_drop    = lb_rd_en_ih && !rd_accept;
    assign wr_err_cnt = wr_reg && (acc_off == REG_ERR_CNT);

    // Clear applies first, then this cycle's increments are added on top
    always_comb begin
        err_inc = 2'(rd_drop) + 2'(lb_wr_en_ih && acc_is_bad) + 2'(rd_accept && acc_is_bad);
        err_sum = {1'b0, (wr_err_cnt ? 16'h0000 : err_cnt)} + 17'(err_inc);
    end

    // Saturating protocol-error counter
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`endif

    // Register read mux, evaluated on the latched offset at capture time
    always_comb begin
        reg_rd_data = '1;
        case (rd_off)
            REG_CONTROL:  reg_rd_data = {{(P_LB_DATA_W-1){1'b0}}, fgyrus_en_oh};
            REG_STATUS:   reg_rd_data = {{(P_LB_DATA_W-2){1'b0}}, (rd_state != S_IDLE), fgyrus_busy_ih};
            REG_PSTATE:   reg_rd_data = {{(P_LB_DATA_W-3){1'b0}}, fgyrus_fsm_pstate_id};
            REG_POSTNORM: reg_rd_data = {{(P_LB_DATA_W-4){1'b0}}, fgyrus_post_norm_od};
            REG_IRQ_STAT: reg_rd_data = {{(P_LB_DATA_W-1){1'b0}}, irq_status};
            REG_IRQ_MASK: reg_rd_data = {{(P_LB_DATA_W-1){1'b0}}, irq_mask};
`ifdef FGYRUS_LB_ERR_CNT_EN
            REG_ERR_CNT:  reg_rd_data = {{(P_LB_DATA_W-16){1'b0}}, err_cnt};
`endif
            default:      reg_rd_data = '1;
        endcase
    end

    // Select returned data: registers, one RAM slice, or all-ones for bad codes
    always_comb begin
        cap_data = '1;
        if (rd_code == CODE_REGS) begin
            cap_data = reg_rd_data;
        end else begin
            for (int k = 0; k < P_NUM_RAMS; k++) begin
                if (rd_code == CODE_W'(k + 1)) begin
                    cap_data = ram_rd_data_id[k*P_LB_DATA_W +: P_LB_DATA_W];
                end
            end
        end
    end

    // Read FSM: strobe once, wait out the RAM latency, capture, then pulse valid
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            rd_state       <= S_IDLE;
            rd_code        <= '0;
            rd_off         <= '0;
            wait_cnt       <= '0;
            ram_rd_en_oh   <= '0;
            lb_rd_valid_od <= 1'b0;
            lb_rd_data_od  <= '1;
        end else begin
            ram_rd_en_oh   <= '0;
            lb_rd_valid_od <= 1'b0;
            case (rd_state)
                S_IDLE: begin
                    if (rd_accept) begin
                        rd_code      <= acc_code;
                        rd_off       <= acc_off;
                        ram_rd_en_oh <= acc_onehot;
                        rd_state     <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    wait_cnt <= WAIT_LOAD;
                    rd_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        lb_rd_data_od  <= cap_data;
                        lb_rd_valid_od <= 1'b1;
                        rd_state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    rd_state <= S_IDLE;
                end
                default: begin
                    rd_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write path; the address bus falls back to the read offset when no write is issued
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            ram_addr_od    <= '0;
            ram_wr_data_od <= '0;
            ram_wr_en_oh   <= '0;
            lb_wr_valid_od <= 1'b0;
        end else begin
            lb_wr_valid_od <= lb_wr_en_ih;
            ram_wr_en_oh   <= lb_wr_en_ih ? acc_onehot : '0;
            if (lb_wr_en_ih) begin
                ram_addr_od    <= acc_off;
                ram_wr_data_od <= lb_wr_data_id;
            end else if (rd_accept) begin
                ram_addr_od    <= acc_off;
            end else begin
                ram_addr_od    <= rd_off;
            end
        end
    end

    // Control registers and interrupt; irq_oh follows the next-state values
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            fgyrus_en_oh        <= 1'b0;
            fgyrus_post_norm_od <= '0;
            irq_mask            <= 1'b0;
            irq_status          <= 1'b0;
            irq_oh              <= 1'b0;
        end else begin
            if (wr_control) begin
                fgyrus_en_oh <= lb_wr_data_id[0];
            end
            if (wr_postnorm) begin
                fgyrus_post_norm_od <= lb_wr_data_id[3:0];
            end
            irq_mask   <= irq_mask_nxt;
            irq_status <= irq_status_nxt;
            irq_oh     <= irq_status_nxt && irq_mask_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/fgyrus_lb_mux.md
# fgyrus_lb_mux

Parametrised local-bus decoder for the fusiform gyrus, routing NIOS local-bus accesses to the FGYRUS control registers and to up to P_NUM_RAMS attached RAMs (FFT real/imag, twiddle, CORDIC, window, …). Successor to the fixed four-RAM decoder. Adds:
- a read FSM that issues a single-cycle RAM read strobe and returns data at a fixed, parameter-defined latency;
- masked, write-1-to-clear interrupt status;
- protocol-error accounting.

It sits between the NIOS local-bus bridge and the FGYRUS datapath RAMs/FSM.

## Interface
Parameters:
- P_LB_ADDR_W, 12, local-bus address width; bits [P_LB_ADDR_W-1:P_LB_ADDR_W-4] are the block code.
- P_LB_DATA_W, 32, local-bus and RAM data width.
- P_RAM_ADDR_W, 8, RAM/register offset width, taken from lb_addr_id[P_RAM_ADDR_W-1:0].
- P_NUM_RAMS, 4, number of RAM channels, 1..15; RAM k uses block code k+1; code 0 selects the registers.
- P_RD_DELAY, 4, read latency in cycles from lb_rd_en_ih to lb_rd_valid_od, ≥3.

Ports:
- clk_ir, in, 1, clock.
- rst_il, in, 1, asynchronous active-low reset.
- lb_rd_en_ih, in, 1, read request.
- lb_wr_en_ih, in, 1, write request.
- lb_addr_id, in, P_LB_ADDR_W, address.
- lb_wr_data_id, in, P_LB_DATA_W, write data.
- lb_rd_valid_od, out, 1, single-cycle read-data-valid pulse.
- lb_wr_valid_od, out, 1, single-cycle write acknowledge.
- lb_rd_data_od, out, P_LB_DATA_W, read data.
- ram_addr_od, out, P_RAM_ADDR_W, RAM address.
- ram_wr_data_od, out, P_LB_DATA_W, RAM write data.
- ram_wr_en_oh, out, P_NUM_RAMS, one-hot write strobes.
- ram_rd_en_oh, out, P_NUM_RAMS, one-hot read strobes.
- ram_rd_data_id, in, P_NUM_RAMS*P_LB_DATA_W, read data; RAM k occupies bits [(k+1)*P_LB_DATA_W-1:k*P_LB_DATA_W].
- fgyrus_en_oh, out, 1, FGYRUS enable.
- fgyrus_post_norm_od, out, 4, post-FFT normalise mode.
- fgyrus_busy_ih, in, 1, FGYRUS FSM busy.
- fgyrus_fsm_pstate_id, in, 3, FGYRUS FSM present state.
- fgyrus_fft_done_ih, in, 1, FFT complete pulse.
- irq_rst_ih, in, 1, clears all interrupt status.
- irq_oh, out, 1, interrupt to NIOS.

## Operation

**Register map** (block code 0, offset = lb_addr_id[7:0]):
- 0x00 CONTROL: [0] fgyrus_en, R/W.
- 0x01 STATUS: [0] fgyrus_busy_ih, [1] read FSM not IDLE, RO.
- 0x02 FSM_PSTATE: [2:0], RO.
- 0x03 POST_NORM: [3:0], R/W.
- 0x04 IRQ_STATUS: [0] fft_done sticky, W1C.
- 0x05 IRQ_MASK: [0], R/W.
- 0x06 ERR_CNT: present only with the macro; see Configuration.
- Unmapped offsets, and block codes > P_NUM_RAMS, read all-ones; writes to them are ignored.
- Register read fields are zero-extended.

**Read FSM:** IDLE → PULSE → WAIT → DONE → IDLE.
- IDLE + lb_rd_en_ih (and not lb_wr_en_ih): latch code and offset; go to PULSE.
- PULSE (1 cycle): ram_rd_en_oh[code-1] = 1; no strobe for code 0. Load wait counter with P_RD_DELAY-3.
- WAIT: decrement the counter. At 0, capture the selected ram_rd_data_id slice (or the register mux, or all-ones), then go to DONE.
- DONE: lb_rd_valid_od = 1 for one cycle; return to IDLE.
- lb_rd_en_ih while not IDLE: dropped, no valid pulse, counted as an error.

**Writes:**
- Always accepted, including during a read.
- Registered one cycle: ram_addr_od, ram_wr_data_od, ram_wr_en_oh[code-1], lb_wr_valid_od.
- Register writes take effect on the same edge.

**Simultaneous events:**
- lb_rd_en_ih and lb_wr_en_ih together: the write is performed, the read is dropped and counted as an error.
- ram_addr_od shows the write address only in a cycle where a write is issued; otherwise it holds the latched read offset.

**Interrupts:**
- IRQ_STATUS[0] is set by fgyrus_fft_done_ih.
- It is cleared by irq_rst_ih or by a W1C write to IRQ_STATUS.
- Set and clear in the same cycle: set wins.
- irq_oh is registered: IRQ_STATUS & IRQ_MASK.

## Timing
- Reset value of every output and register is 0, except lb_rd_data_od, which resets to all-ones.
- Read accepted at edge N: ram_rd_en_oh pulses in cycle N+1, and lb_rd_valid_od with data appears in cycle N+P_RD_DELAY.
- RAM data must be stable by cycle N+P_RD_DELAY-1, i.e. within P_RD_DELAY-2 cycles of the strobe.
- Back-to-back reads: the earliest next accepted request is in cycle N+P_RD_DELAY+1 (the FSM is back in IDLE after DONE).
- Write at N: strobe and lb_wr_valid_od in cycle N+1, exactly one cycle each.
- Register reads have the same P_RD_DELAY latency; the register mux is sampled at capture time, so a write landing before capture is visible in the returned data.
- Reset mid-read: FSM returns to IDLE immediately; no valid pulse is issued for the aborted read.

## Configuration
- FGYRUS_LB_ERR_CNT_EN defined:
  - ERR_CNT register at 0x06 holds [15:0], saturating at 0xFFFF.
  - It increments once per dropped read and once per access to a block code > P_NUM_RAMS.
  - Any write to ERR_CNT clears it; an increment in the same cycle wins and leaves the count at 1.
- FGYRUS_LB_ERR_CNT_EN undefined: no counter logic; offset 0x06 reads all-ones; writes to it are ignored.

## Test plan
- Reset, then read CONTROL at N → lb_rd_valid_od and data 0x00000000 at N+4; no ram_rd_en_oh pulse.
- Write 0x12345678 to code 2, offset 0x10 → ram_wr_en_oh = 4'b0010, ram_addr_od = 0x10 and lb_wr_valid_od for one cycle; then read code 2 with the RAM model returning 0xCAFEF00D → exactly one ram_rd_en_oh[1] pulse, and 0xCAFEF00D at N+4.
- Read issued at N and again at N+2 → a single valid pulse at N+4; with the macro, ERR_CNT reads 1.
- Simultaneous read and write to POST_NORM with data 0x5 → fgyrus_post_norm_od = 4'h5, no valid pulse, ERR_CNT = 1.
- IRQ_MASK = 1, pulse fgyrus_fft_done_ih → irq_oh rises one cycle later; a W1C write coinciding with another done pulse leaves irq_oh = 1; a subsequent irq_rst_ih drops it.
- Assert rst_il mid-WAIT → FSM in IDLE, no valid pulse, all outputs at reset values; a fresh read completes normally.
